// File: rtl/and_gate_tester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | and_gate_tester: exhaustive sweep / ring-oscillator tester for twelve      |
// | 6-input AND variants sharing one stimulus bus.                             |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module and_gate_tester #(
  parameter int SETTLE   = 4,
  parameter int WIN_LOG2 = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [3:0]       sel,
  input  logic [11:0]      y,
  output logic [5:0]       a,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [6:0]       err_cnt,
  output logic [CNT_W-1:0] count
);

  localparam int TW = (WIN_LOG2 > 8) ? WIN_LOG2 : 8;
  localparam logic [TW-1:0] C_SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] C_WARM_LAST   = TW'(15);
  localparam logic [TW-1:0] C_WIN_LAST    = TW'((64'd1 << WIN_LOG2) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_WARM   = 3'd4,
    S_RCOUNT = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t        r_state;
  logic          r_mode;
  logic [3:0]    r_sel;
  logic [5:0]    r_pat;
  logic [TW-1:0] r_timer;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;

  logic [15:0]      w_y_ext;
  logic             w_ybit;
  logic             w_mismatch;
  logic [6:0]       w_err_next;
  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;

  // Pad y so that invalid selects read a constant 0 instead of indexing out of range.
  assign w_y_ext    = {4'b0000, y};
  assign w_ybit     = w_y_ext[r_sel];
  assign w_mismatch = r_sync2 != (r_pat == 6'd63);
  assign w_err_next = (w_mismatch && (err_cnt < 7'd64)) ? err_cnt + 7'd1 : err_cnt;
  assign w_rise     = r_sync2 & ~r_prev;
  assign w_cnt_next = (w_rise && (count != {CNT_W{1'b1}})) ? count + CNT_W'(1) : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_sel   <= 4'd0;
      r_pat   <= 6'd0;
      r_timer <= '0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      a       <= 6'd0;
      osc_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= 7'd0;
      count   <= '0;
    end else begin
      done    <= 1'b0;
      r_sync1 <= w_ybit;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        S_IDLE: begin
          // busy in IDLE marks the dispatch cycle following an accepted start
          if (busy) begin
            r_pat   <= 6'd0;
            r_timer <= '0;
            if (r_sel > 4'd11) begin
              r_state <= S_FIN;
              done    <= 1'b1;
              busy    <= 1'b0;
              pass    <= 1'b0;
            end else if (r_mode) begin
              r_state <= S_WARM;
              a       <= 6'h3F;
              osc_en  <= 1'b1;
            end else begin
              r_state <= S_APPLY;
              a       <= 6'd0;
            end
          end else if (start) begin
            r_mode  <= mode;
            r_sel   <= sel;
            busy    <= 1'b1;
            pass    <= 1'b0;
            err_cnt <= 7'd0;
            count   <= '0;
          end
        end
        S_APPLY: begin
          r_state <= S_SETTLE;
          r_timer <= '0;
        end
        S_SETTLE: begin
          if (r_timer == C_SETTLE_LAST) r_state <= S_CHECK;
          else                          r_timer <= r_timer + 1'b1;
        end
        S_CHECK: begin
          err_cnt <= w_err_next;
          if (r_pat == 6'd63) begin
            r_state <= S_FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (w_err_next == 7'd0);
            a       <= 6'd0;
          end else begin
            r_pat   <= r_pat + 6'd1;
            a       <= r_pat + 6'd1;
            r_state <= S_APPLY;
          end
        end
        S_WARM: begin
          if (r_timer == C_WARM_LAST) begin
            r_state <= S_RCOUNT;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RCOUNT: begin
          count <= w_cnt_next;
          if (r_timer == C_WIN_LAST) begin
            r_state <= S_FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
            osc_en  <= 1'b0;
            a       <= 6'd0;
            pass    <= (w_cnt_next != '0);
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_and_gate_tester.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_and_gate_tester: randomized bench with a schedule-level reference model |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_and_gate_tester;

  localparam int SETTLE    = 4;
  localparam int WIN_LOG2  = 10;
  localparam int CNT_W     = 16;
  localparam int WIN       = 1 << WIN_LOG2;
  localparam int SWEEP_LAT = 64 * (SETTLE + 2) + 1;
  localparam int RING_LAT  = 16 + WIN + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [3:0]       sel;
  logic [11:0]      y;
  logic [5:0]       a;
  logic             osc_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic [6:0]       err_cnt;
  logic [CNT_W-1:0] count;

  and_gate_tester #(.SETTLE(SETTLE), .WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel), .y(y),
    .a(a), .osc_en(osc_en), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // External AND variants: lane cfg_lane is either faulty on the patterns in
  // cfg_fault, or a square wave of period cfg_period (0 = stuck low).
  logic [63:0] cfg_fault  = '0;
  int          cfg_lane   = 0;
  bit          cfg_sq     = 1'b0;
  int          cfg_period = 0;
  int          sq_t       = 0;

  always @(posedge clk) begin
    sq_t <= sq_t + 1;
    for (int k = 0; k < 12; k++) begin
      if (k == cfg_lane && cfg_sq)
        y[k] <= (cfg_period == 0) ? 1'b0 : ((sq_t % cfg_period) < (cfg_period / 2));
      else if (k == cfg_lane)
        y[k] <= (&a) ^ cfg_fault[a];
      else
        y[k] <= &a;
    end
  end

  // Reference model: tracks edges since the accepted start and the final verdict.
  bit m_act = 1'b0;
  int m_k = 0, m_L = 0, m_kind = 0;
  int m_err = 0, m_lo = 0, m_hi = 0;
  bit m_pass = 1'b0;
  int m_accepts = 0, m_aborts = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (m_act) m_aborts++;
      m_act = 1'b0; m_err = 0; m_lo = 0; m_hi = 0; m_pass = 1'b0;
    end else if (m_act) begin
      m_k++;
      if (m_k > m_L) m_act = 1'b0;
    end else if (start) begin
      m_act = 1'b1; m_k = 0; m_accepts++;
      m_err = 0; m_lo = 0; m_hi = 0; m_pass = 1'b0;
      if (sel > 11) begin
        m_kind = 2; m_L = 1;
      end else if (mode) begin
        int per;
        m_kind = 1; m_L = RING_LAT;
        per  = (cfg_sq && cfg_lane == int'(sel)) ? cfg_period : 0;
        m_lo = (per > 0) ? WIN / per : 0;
        m_hi = (per > 0) ? (WIN + per - 1) / per : 0;
        m_pass = (m_lo > 0);
      end else begin
        m_kind = 0; m_L = SWEEP_LAT;
        m_err  = (!cfg_sq && cfg_lane == int'(sel)) ? $countones(cfg_fault) : 0;
        if (m_err > 64) m_err = 64;
        m_pass = (m_err == 0);
      end
    end
  end

  bit chk_en  = 1'b0;
  int n_done  = 0;
  int osc_cyc = 0;

  always @(negedge clk) begin : cmp
    int ea, eb, eo, ed;
    if (chk_en) begin
      ea = 0; eb = 0; eo = 0; ed = 0;
      if (m_act) begin
        eb = (m_k < m_L) ? 1 : 0;
        ed = (m_k == m_L) ? 1 : 0;
        if (m_kind == 0 && m_k >= 1 && m_k < m_L) ea = (m_k - 1) / (SETTLE + 2);
        if (m_kind == 1 && m_k >= 1 && m_k < m_L) begin ea = 63; eo = 1; end
      end
      check("a", a, ea, ea);
      check("busy", busy, eb, eb);
      check("osc_en", osc_en, eo, eo);
      check("done", done, ed, ed);
      if (!m_act || m_k == m_L) begin
        check("pass", pass, m_pass, m_pass);
        check("err_cnt", err_cnt, m_err, m_err);
        check("count", count, m_lo, m_hi);
      end
      if (done) n_done++;
      if (osc_en) osc_cyc++;
    end
  end

  task automatic go(input bit md, input logic [3:0] s, output int lat);
    @(negedge clk); start = 1'b1; mode = md; sel = s;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", lat, 0, 1999);
  endtask

  task automatic cfg_sweep(input int lane, input logic [63:0] f);
    cfg_sq = 1'b0; cfg_lane = lane; cfg_fault = f;
  endtask

  task automatic cfg_ring(input int lane, input int per);
    cfg_sq = 1'b1; cfg_lane = lane; cfg_period = per; cfg_fault = '0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); chk_en = 1'b1;
    check("rst_a", a, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_count", count, 0, 0);
    rst = 1'b0;

    cfg_sweep(5, 64'd0);
    go(1'b0, 4'd5, lat);
    check("ideal_lat", lat, 385, 385);
    check("ideal_pass", pass, 1, 1);
    check("ideal_err", err_cnt, 0, 0);

    cfg_sweep(3, 64'h8000_0000_0000_0000);
    go(1'b0, 4'd3, lat);
    check("stuck0_err", err_cnt, 1, 1);
    check("stuck0_pass", pass, 0, 0);

    cfg_sweep(3, 64'h7FFF_FFFF_FFFF_FFFF);
    go(1'b0, 4'd3, lat);
    check("stuck1_err", err_cnt, 63, 63);
    check("stuck1_pass", pass, 0, 0);

    cfg_ring(0, 8);
    osc_cyc = 0;
    go(1'b1, 4'd0, lat);
    check("ring_lat", lat, 1041, 1041);
    check("ring_count", count, 127, 129);
    check("ring_pass", pass, 1, 1);
    check("ring_osc_cycles", osc_cyc, 1040, 1040);

    cfg_ring(4, 0);
    go(1'b1, 4'd4, lat);
    check("ring0_count", count, 0, 0);
    check("ring0_pass", pass, 0, 0);

    go(1'b0, 4'd13, lat);
    check("inv0_lat", lat, 1, 1);
    check("inv0_pass", pass, 0, 0);
    go(1'b1, 4'd13, lat);
    check("inv1_lat", lat, 1, 1);

    // Abort at pattern 20, with start held alongside reset
    cfg_sweep(2, 64'd0);
    @(negedge clk); start = 1'b1; mode = 1'b0; sel = 4'd2;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (a != 6'd20 && lat < 500) begin @(negedge clk); lat++; end
    check("reach_p20", a, 20, 20);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0, 0);
    check("abort_done", done, 0, 0);
    go(1'b0, 4'd2, lat);
    check("after_abort_lat", lat, 385, 385);
    check("after_abort_pass", pass, 1, 1);

    // Re-pulse start while busy and in the FIN cycle
    cfg_sweep(7, 64'h0000_0100_0000_0001);
    @(negedge clk); start = 1'b1; mode = 1'b0; sel = 4'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 1'b1; sel = 4'd0;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 2000) begin @(negedge clk); lat++; end
    check("repulse_err", err_cnt, 2, 2);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("fin_start_ignored", busy, 0, 0);

    for (int it = 0; it < 10; it++) begin
      int kind, lane;
      logic [63:0] f;
      kind = $urandom_range(0, 2);
      lane = $urandom_range(0, 11);
      if (kind == 0) begin
        f = '0;
        if ($urandom_range(0, 2) != 0)
          for (int b = 0; b < 64; b++) f[b] = ($urandom_range(0, 15) == 0);
        cfg_sweep(lane, f);
        go(1'b0, 4'(lane), lat);
      end else if (kind == 1) begin
        cfg_ring(lane, ($urandom_range(0, 5) == 0) ? 0 : 2 * $urandom_range(1, 16));
        go(1'b1, 4'(lane), lat);
      end else begin
        go(1'($urandom_range(0, 1)), 4'($urandom_range(12, 15)), lat);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("done_pulses", n_done, m_accepts - m_aborts, m_accepts - m_aborts);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
